// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops a registered-read FIFO and re-presents its words as a valid/ready stream.
// Define FIFO_RD_STREAM_STATS_EN to add saturating stat_words / stat_stalls counters.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 4,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [31:0]           stat_stalls
`endif
);

  generate
    if (BUF_DEPTH != 2) begin : g_bad_depth
      $error("fifo_rd_stream: BUF_DEPTH must be 2");
    end
  endgenerate

  logic [1:0]            r_occ;
  logic                  r_in_flight;
  logic [DATA_WIDTH-1:0] r_buf   [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] w_shift [BUF_DEPTH];
  logic                  w_fire;
  logic [2:0]            w_level;
  logic [1:0]            w_wr_idx;

  assign m_valid  = (r_occ != 2'd0);
  assign m_data   = r_buf[0];
  assign w_fire   = m_valid & m_ready;
  // Words owed to the buffer after this edge: held + arriving - leaving.
  assign w_level  = {1'b0, r_occ} + {2'b00, r_in_flight} - {2'b00, w_fire};
  assign fifo_rd_en = rst_n & ~fifo_rd_empty & (w_level < 3'd2);
  assign w_wr_idx = r_occ - {1'b0, w_fire};

  genvar gi;
  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_shift
      if (gi == BUF_DEPTH - 1) begin : g_last
        assign w_shift[gi] = r_buf[gi];
      end else begin : g_mid
        assign w_shift[gi] = r_buf[gi + 1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ       <= 2'd0;
      r_in_flight <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_in_flight <= fifo_rd_en;
      r_occ       <= r_occ + {1'b0, r_in_flight} - {1'b0, w_fire};
      // The arriving word lands behind whatever survives this edge's pop.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (r_in_flight && (w_wr_idx == 2'(i))) begin
          r_buf[i] <= fifo_rd_data;
        end else if (w_fire) begin
          r_buf[i] <= w_shift[i];
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, r_occ} + {2'b00, r_in_flight}) <= 3'd2);

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] r_words;
  logic [31:0] r_stalls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words  <= 32'd0;
      r_stalls <= 32'd0;
    end else begin
      if (w_fire && (r_words != 32'hFFFF_FFFF)) begin
        r_words <= r_words + 32'd1;
      end
      if (m_valid && !m_ready && (r_stalls != 32'hFFFF_FFFF)) begin
        r_stalls <= r_stalls + 32'd1;
      end
    end
  end

  assign stat_words  = r_words;
  assign stat_stalls = r_stalls;
`endif

endmodule
